divide_bits: RTL and testbench
==============================

DIVIDE_BITS -- requirements
Module: divide_bits

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports CLK and RST.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 START  input  1  request to begin a division; sampled only in IDLE.
REQ-005 A  input  8  unsigned dividend; captured on the accepting edge.
REQ-006 B  input  8  unsigned divisor; captured on the accepting edge.
REQ-007 Q  output  8  quotient, registered.
REQ-008 R  output  8  remainder, registered.
REQ-009 BUSY  output  1  high while in CALC or DONE.
REQ-010 DONE  output  1  one-cycle pulse; Q, R and DIVZ are valid while it is high.
REQ-011 DIVZ  output  1  high when the captured divisor was zero; valid with DONE.

Function
REQ-012 The block SHALL compute Q = A / B and R = A mod B, unsigned, using restoring shift-and-subtract at one quotient bit per cycle.
REQ-013 The partial remainder SHALL be 9 bits wide.
- Each step: shift the remainder left, bringing in the next dividend bit, MSB first.
- Trial-subtract the zero-extended divisor.
- If there is no borrow: keep the difference and set the quotient bit to 1.
- Otherwise: restore the remainder and set the quotient bit to 0.
REQ-014 The block SHALL have three states: IDLE, CALC and DONE, plus a 3-bit step counter.
REQ-015 IDLE with START=1 at edge N SHALL:
- capture A and B;
- clear the working remainder;
- set the counter to 0;
- go to CALC.
REQ-016 CALC SHALL perform exactly one step per edge, at edges N+1 through N+8. After the step at edge N+8, it SHALL go to DONE.
REQ-017 In DONE, DONE=1 for exactly one cycle. Q and R SHALL be updated on the edge that enters DONE.
REQ-018 DONE SHALL go to IDLE on the following edge unconditionally.
REQ-019 Q, R and DIVZ SHALL hold their last values in IDLE until the next accepted START.
REQ-020 START SHALL be ignored while BUSY=1; no queuing.
REQ-021 Changes on A and B after the accepting edge SHALL NOT affect the result.
REQ-022 START asserted in the DONE cycle SHALL be ignored. START asserted in the first IDLE cycle after DONE SHALL be accepted, giving back-to-back operation every 10 cycles.
REQ-023 Divide-by-zero (B=0 captured) SHALL produce Q=8'hFF, R=A and DIVZ=1. These are exactly the values the restoring algorithm produces naturally.
REQ-024 DIVZ SHALL be 0 for every nonzero divisor.

Reset
REQ-025 RST=1 at an edge SHALL force IDLE and set Q=0, R=0, BUSY=0, DONE=0 and DIVZ=0. It SHALL also clear the counter and the working registers.
REQ-026 RST SHALL take priority over START and over any in-progress operation.
REQ-027 A reset during CALC or DONE SHALL abort the operation with no DONE pulse.
REQ-028 START sampled on the same edge as RST=1 SHALL be discarded.

Configuration
REQ-029 Macro DIVZ_EARLY_EN SHALL select zero-divisor latency only.
- Defined: B=0 on the accepting edge N goes directly IDLE->DONE at edge N. DONE is high in the cycle after edge N, with Q=8'hFF, R=A and DIVZ=1.
- Undefined: a zero divisor runs all 8 CALC steps like any other operand. DONE is high in the cycle after edge N+8, with the same Q, R and DIVZ.
REQ-030 Results and all nonzero-divisor timing SHALL be identical with and without DIVZ_EARLY_EN.

Verification
REQ-031 A=100, B=7, START at edge N -> BUSY=1 from edge N, DONE=1 in the single cycle after edge N+8, Q=14, R=2, DIVZ=0; BUSY=0 after edge N+9.
REQ-032 A=255, B=1 -> Q=255, R=0. A=5, B=9 -> Q=0, R=5. A=200, B=200 -> Q=1, R=0.
REQ-033 A=77, B=0 -> Q=8'hFF, R=77, DIVZ=1. DONE follows edge N with DIVZ_EARLY_EN defined, and edge N+8 without it.
REQ-034 START held high through a run, with A/B changed mid-run to 9/3 -> the first result is unaffected. The second run is accepted only at the first IDLE edge and gives Q=3, R=0.
REQ-035 RST=1 at edge N+4 of a 100/7 run -> no DONE pulse; Q=0, R=0, BUSY=0, DIVZ=0. A new START afterwards completes normally.
REQ-036 Exhaustive sweep: all A x B with B != 0 in both macro builds -> Q and R match A/B and A%B; DONE pulse width is always exactly 1 cycle.

Source files
------------

// File: rtl/divide_bits.sv
// divide_bits: 8-bit unsigned restoring divider, one quotient bit per clock.
// Optional build macro: DIVZ_EARLY_EN. When it is defined, a zero divisor skips the CALC
// steps and goes straight from IDLE to DONE with the same result values.
module divide_bits (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] Q,
    output logic [7:0] R,
    output logic       BUSY,
    output logic       DONE,
    output logic       DIVZ
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [7:0]  work_q, work_d;
    logic [7:0]  div_q, div_d;
    logic [8:0]  rem_q, rem_d;
    logic [7:0]  quo_q, quo_d;
    logic [7:0]  res_q, res_d;
    logic        divz_q, divz_d;

    logic [8:0]  rem_shift;
    logic [9:0]  diff;
    logic        no_borrow;
    logic [8:0]  rem_step;
    logic [7:0]  work_step;

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
    always_comb begin
        rem_shift = {rem_q[7:0], work_q[7]};
        diff      = {1'b0, rem_shift} - {2'b00, div_q};
        no_borrow = ~diff[9];
        rem_step  = no_borrow ? diff[8:0] : rem_shift;
        work_step = {work_q[6:0], no_borrow};
    end

    // Next-state logic and outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        div_d   = div_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        res_d   = res_q;
        divz_d  = divz_q;

        unique case (state_q)
            StIdle: begin
                if (START) begin
                    work_d = A;
                    div_d  = B;
                    rem_d  = 9'd0;
                    cnt_d  = 3'd0;
`ifdef DIVZ_EARLY_EN
                    if (B == 8'd0) begin
                        // Same values the full iteration would reach for a zero divisor.
                        state_d = StDone;
                        quo_d   = 8'hFF;
                        res_d   = A;
                        divz_d  = 1'b1;
                    end else begin
                        state_d = StCalc;
                    end
`else
                    state_d = StCalc;
`endif
                end
            end
            StCalc: begin
                rem_d  = rem_step;
                work_d = work_step;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = StDone;
                    quo_d   = work_step;
                    // Final remainder is below the divisor, so it always fits 8 bits.
                    res_d   = rem_step[7:0];
                    divz_d  = (div_q == 8'd0);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        BUSY = (state_q != StIdle);
        DONE = (state_q == StDone);
        Q    = quo_q;
        R    = res_q;
        DIVZ = divz_q;
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            work_q  <= 8'd0;
            div_q   <= 8'd0;
            rem_q   <= 9'd0;
            quo_q   <= 8'd0;
            res_q   <= 8'd0;
            divz_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            div_q   <= div_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
            divz_q  <= divz_d;
        end
    end

endmodule

// File: tb/tb_divide_bits.sv
// Scoreboard bench for divide_bits: the driver queues expected results, the monitor
// checks them (values and arrival cycle) whenever DONE is seen.
module tb_divide_bits;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] Q;
    logic [7:0] R;
    logic       BUSY;
    logic       DONE;
    logic       DIVZ;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         at;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

`ifdef DIVZ_EARLY_EN
    localparam int ZeroLat = 1;
`else
    localparam int ZeroLat = 9;
`endif

    divide_bits dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .DIVZ  (DIVZ)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on every DONE; also check pulse width.
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (DONE) begin
                chk("done_width", int'(done_prev), 0);
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("q", int'(Q), int'(e.q));
                    chk("r", int'(R), int'(e.r));
                    chk("divz", int'(DIVZ), int'(e.z));
                    chk("done_cycle", cyc, e.at);
                end
            end
            done_prev = DONE;
        end
    end

    // Wait (bounded) until every queued result has been seen by the monitor.
    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 40) begin
            @(negedge CLK);
            #1;
            n++;
        end
        if (sbq.size() != 0) begin
            chk("drain_timeout", sbq.size(), 0);
            sbq.delete();
        end
    endtask

    // Issue one division with hand-computed expectations, scramble inputs afterwards.
    task automatic run(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] eq, input logic [7:0] er, input logic ez);
        exp_t e;
        int n;
        n = 0;
        @(negedge CLK);
        while (BUSY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        A = a;
        B = b;
        START = 1'b1;
        e.q = eq;
        e.r = er;
        e.z = ez;
        e.at = cyc + ((b == 8'd0) ? ZeroLat : 9);
        sbq.push_back(e);
        @(negedge CLK);
        START = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        chk("busy_after_accept", int'(BUSY), 1);
        drain();
        @(negedge CLK);
        chk("busy_after_done", int'(BUSY), 0);
    endtask

    initial begin
        exp_t e;
        int n;
        RST = 1'b1;
        START = 1'b0;
        A = 8'd0;
        B = 8'd0;
        repeat (2) @(negedge CLK);
        chk("rst_q", int'(Q), 0);
        chk("rst_r", int'(R), 0);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_divz", int'(DIVZ), 0);
        RST = 1'b0;

        run(8'd100, 8'd7,   8'd14,  8'd2,  1'b0);
        run(8'd255, 8'd1,   8'd255, 8'd0,  1'b0);
        run(8'd5,   8'd9,   8'd0,   8'd5,  1'b0);
        run(8'd200, 8'd200, 8'd1,   8'd0,  1'b0);
        run(8'd77,  8'd0,   8'hFF,  8'd77, 1'b1);
        run(8'd0,   8'd0,   8'hFF,  8'd0,  1'b1);
        run(8'd171, 8'd13,  8'd13,  8'd2,  1'b0);
        run(8'd254, 8'd16,  8'd15,  8'd14, 1'b0);
        run(8'd128, 8'd3,   8'd42,  8'd2,  1'b0);
        run(8'd1,   8'd255, 8'd0,   8'd1,  1'b0);
        run(8'd255, 8'd2,   8'd127, 8'd1,  1'b0);
        run(8'd0,   8'd5,   8'd0,   8'd0,  1'b0);

        // Outputs hold in IDLE after a result.
        repeat (3) @(negedge CLK);
        chk("hold_q", int'(Q), 0);
        chk("hold_r", int'(R), 0);

        // START held high; operands change mid-run; second run starts at first IDLE edge.
        @(negedge CLK);
        A = 8'd100;
        B = 8'd7;
        START = 1'b1;
        e.q = 8'd14; e.r = 8'd2; e.z = 1'b0; e.at = cyc + 9;
        sbq.push_back(e);
        e.q = 8'd3;  e.r = 8'd0; e.z = 1'b0; e.at = cyc + 19;
        sbq.push_back(e);
        repeat (3) @(negedge CLK);
        A = 8'd9;
        B = 8'd3;
        n = 0;
        while (sbq.size() != 1 && n < 20) begin
            @(negedge CLK);
            #1;
            n++;
        end
        @(negedge CLK);
        @(negedge CLK);
        START = 1'b0;
        drain();

        // Reset at edge N+4 aborts a run without any DONE pulse.
        @(negedge CLK);
        A = 8'd100;
        B = 8'd7;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_q", int'(Q), 0);
        chk("abort_r", int'(R), 0);
        chk("abort_busy", int'(BUSY), 0);
        chk("abort_done", int'(DONE), 0);
        chk("abort_divz", int'(DIVZ), 0);
        repeat (12) @(negedge CLK);
        run(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);

        // START on the same edge as RST is discarded.
        @(negedge CLK);
        RST = 1'b1;
        START = 1'b1;
        A = 8'd50;
        B = 8'd5;
        @(negedge CLK);
        RST = 1'b0;
        START = 1'b0;
        chk("rst_start_busy", int'(BUSY), 0);
        repeat (12) @(negedge CLK);
        chk("rst_start_q", int'(Q), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
